adc_capture_ctrl: RTL and testbench

Triggered capture sequencer for the AD9238 dual-channel sample stream. It runs in the ADC sampling clock domain. On an arm command it writes every sample pair from both channels into a circular capture RAM. It keeps a programmable pre-trigger history, detects a level-crossing or forced trigger, writes the post-trigger remainder, then stops and reports where the record starts. It sits between the ADC input pins and the capture buffer RAM, and owns that RAM's write port.

---
 rtl/adc_capture_ctrl.sv | 172 +++++++++++++++++
 tb/tb_adc_capture_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl.sv
// adc_capture_ctrl: triggered capture sequencer for a dual-channel ADC stream.
// On arm it writes one {ch1, ch0} sample pair per cycle into a circular
// capture RAM. It keeps a programmable pre-trigger history and waits for a
// level crossing or a forced trigger. It then writes the post-trigger
// remainder, stops, and reports where the record starts.
module adc_capture_ctrl #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 11
) (
  input  logic                  adc_clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  force_trig,
  input  logic                  trig_src,
  input  logic                  trig_edge,
  input  logic [DATA_W-1:0]     trig_level,
  input  logic [ADDR_W-1:0]     pretrig_len,
  input  logic [DATA_W-1:0]     adc_data_ch0,
  input  logic [DATA_W-1:0]     adc_data_ch1,
  output logic                  buf_wr,
  output logic [ADDR_W-1:0]     buf_addr,
  output logic [2*DATA_W-1:0]   buf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_W-1:0]     trig_addr,
  output logic [ADDR_W-1:0]     start_addr
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t state_reg, state_next;

  // Trigger settings latched at arm so they stay stable for the whole record
  logic                     src_reg;
  logic                     edge_reg;
  logic signed [DATA_W-1:0] level_reg;
  logic [ADDR_W-1:0]        pre_len_reg;

  logic [ADDR_W-1:0]        wptr_reg;
  logic [ADDR_W-1:0]        pre_cnt_reg;
  logic [ADDR_W-1:0]        post_cnt_reg;
  logic signed [DATA_W-1:0] prev_reg;
  logic                     prev_valid_reg;

  logic                     buf_wr_reg;
  logic [ADDR_W-1:0]        buf_addr_reg;
  logic [2*DATA_W-1:0]      buf_wdata_reg;
  logic                     done_reg;
  logic [ADDR_W-1:0]        trig_addr_reg;
  logic [ADDR_W-1:0]        start_addr_reg;

  logic signed [DATA_W-1:0] cur_sample;
  logic                     rise_hit;
  logic                     fall_hit;
  logic                     trig_fire;
  logic [ADDR_W-1:0]        pre_cnt_inc;
  logic [ADDR_W-1:0]        post_init;

  assign cur_sample  = src_reg ? adc_data_ch1 : adc_data_ch0;
  assign rise_hit    = (prev_reg <  level_reg) && (cur_sample >= level_reg);
  assign fall_hit    = (prev_reg >= level_reg) && (cur_sample <  level_reg);
  assign trig_fire   = (state_reg == S_WAIT) &&
                       (force_trig || (prev_valid_reg && (edge_reg ? fall_hit : rise_hit)));
  assign pre_cnt_inc = pre_cnt_reg + 1'b1;
  // DEPTH - pretrig_len - 1 is the bitwise complement in ADDR_W bits
  assign post_init   = ~pre_len_reg;

  // State register
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; abort overrides every other transition
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (arm) state_next = (pretrig_len != '0) ? S_PRE : S_WAIT;
      end
      S_PRE: begin
        if (pre_cnt_inc == pre_len_reg) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (trig_fire) state_next = (post_init == '0) ? S_DONE : S_POST;
      end
      S_POST: begin
        if (post_cnt_reg == ADDR_W'(1)) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // Output decode: busy covers every state that writes samples
  always_comb begin
    busy = (state_reg == S_PRE) || (state_reg == S_WAIT) || (state_reg == S_POST);
  end

  // Capture datapath: one RAM write per busy cycle, trigger bookkeeping
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      src_reg        <= 1'b0;
      edge_reg       <= 1'b0;
      level_reg      <= '0;
      pre_len_reg    <= '0;
      wptr_reg       <= '0;
      pre_cnt_reg    <= '0;
      post_cnt_reg   <= '0;
      prev_reg       <= '0;
      prev_valid_reg <= 1'b0;
      buf_wr_reg     <= 1'b0;
      buf_addr_reg   <= '0;
      buf_wdata_reg  <= '0;
      done_reg       <= 1'b0;
      trig_addr_reg  <= '0;
      start_addr_reg <= '0;
    end else begin
      buf_wr_reg <= 1'b0;
      if (abort) begin
        prev_valid_reg <= 1'b0;
        trig_addr_reg  <= '0;
        start_addr_reg <= '0;
      end else if (arm && !busy) begin
        src_reg        <= trig_src;
        edge_reg       <= trig_edge;
        level_reg      <= trig_level;
        pre_len_reg    <= pretrig_len;
        wptr_reg       <= '0;
        pre_cnt_reg    <= '0;
        prev_valid_reg <= 1'b0;
        trig_addr_reg  <= '0;
        start_addr_reg <= '0;
      end else if (busy) begin
        buf_wr_reg     <= 1'b1;
        buf_addr_reg   <= wptr_reg;
        buf_wdata_reg  <= {adc_data_ch1, adc_data_ch0};
        wptr_reg       <= wptr_reg + 1'b1;
        prev_reg       <= cur_sample;
        prev_valid_reg <= 1'b1;
        if (state_reg == S_PRE) pre_cnt_reg <= pre_cnt_inc;
        if (trig_fire) begin
          trig_addr_reg  <= wptr_reg;
          start_addr_reg <= wptr_reg - pre_len_reg;
          post_cnt_reg   <= post_init;
        end else if (state_reg == S_POST) begin
          post_cnt_reg <= post_cnt_reg - 1'b1;
        end
      end
      // done rises the cycle after the last write, i.e. when buf_wr drops
      done_reg <= (state_reg == S_DONE) && (state_next == S_DONE);
    end
  end

  assign buf_wr     = buf_wr_reg;
  assign buf_addr   = buf_addr_reg;
  assign buf_wdata  = buf_wdata_reg;
  assign done       = done_reg;
  assign trig_addr  = trig_addr_reg;
  assign start_addr = start_addr_reg;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// tb_adc_capture_ctrl: table-driven and randomized capture runs against a
// record-level model (trigger index from the crossing rule, record length
// and addresses from modular arithmetic).
module tb_adc_capture_ctrl;

  localparam int DATA_W = 12;
  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              adc_clk = 1'b0;
  logic              rst = 1'b1;
  logic              arm = 1'b0;
  logic              abort = 1'b0;
  logic              force_trig = 1'b0;
  logic              trig_src = 1'b0;
  logic              trig_edge = 1'b0;
  logic [11:0]       trig_level = '0;
  logic [10:0]       pretrig_len = '0;
  logic [11:0]       adc_data_ch0 = '0;
  logic [11:0]       adc_data_ch1 = '0;
  logic              buf_wr;
  logic [10:0]       buf_addr;
  logic [23:0]       buf_wdata;
  logic              busy;
  logic              done;
  logic [10:0]       trig_addr;
  logic [10:0]       start_addr;

  int n_chk  = 0;
  int n_fail = 0;

  adc_capture_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .adc_clk      (adc_clk),
    .rst          (rst),
    .arm          (arm),
    .abort        (abort),
    .force_trig   (force_trig),
    .trig_src     (trig_src),
    .trig_edge    (trig_edge),
    .trig_level   (trig_level),
    .pretrig_len  (pretrig_len),
    .adc_data_ch0 (adc_data_ch0),
    .adc_data_ch1 (adc_data_ch1),
    .buf_wr       (buf_wr),
    .buf_addr     (buf_addr),
    .buf_wdata    (buf_wdata),
    .busy         (busy),
    .done         (done),
    .trig_addr    (trig_addr),
    .start_addr   (start_addr)
  );

  always #5 adc_clk = ~adc_clk;

  typedef struct {
    string name;
    int    pre;
    bit    src;
    bit    edg;
    int    level;
    int    kind;       // 0 noise, 1 ch0 ramp, 2 ch1 step down, 3 ch0 pulses, 4 zero
    int    force_a;
    int    force_b;
    int    arm_at;     // capture index at which a stray arm is pulsed
    int    stop_at;    // capture index at which abort/rst is applied
    int    stop_kind;  // 1 abort, 2 rst
    int    exp_trig;   // -1: model only
    int    exp_start;
    int    exp_writes;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic bit crossing(input int prev, input int cur, input int lvl, input bit edg);
    if (!edg) return (prev < lvl) && (cur >= lvl);
    return (prev >= lvl) && (cur < lvl);
  endfunction

  function automatic logic [11:0] noise(input int lvl);
    return 12'(lvl + int'($urandom_range(0, 64)) - 32);
  endfunction

  task automatic run_case(input vec_t v);
    int idx = 0;
    int t_exp = -1;
    int n_exp = -1;
    bit finished = 0;
    bit stopped = 0;
    logic signed [11:0] d0, d1, sel, prev_sel;
    int exp_t_addr, exp_s_addr;
    prev_sel = '0;
    @(negedge adc_clk);
    arm = 1'b1;
    trig_src = v.src;
    trig_edge = v.edg;
    trig_level = 12'(v.level);
    pretrig_len = 11'(v.pre);
    @(negedge adc_clk);
    arm = 1'b0;
    chk({v.name, "_busy_after_arm"}, 64'(busy), 64'd1);
    chk({v.name, "_done_after_arm"}, 64'(done), 64'd0);
    for (int cyc = 0; cyc < 8000 && !finished; cyc++) begin
      case (v.kind)
        0: begin d0 = noise(v.level); d1 = noise(v.level); end
        1: begin d0 = 12'(-100 + idx); d1 = 12'($urandom); end
        2: begin d0 = 12'($urandom); d1 = (idx < 2999) ? 12'(500) : 12'(-500); end
        3: begin
          d0 = (idx < 10) ? 12'(-10) : (idx < 200) ? 12'(10) : (idx < 300) ? 12'(-10) : 12'(10);
          d1 = 12'($urandom);
        end
        default: begin d0 = '0; d1 = '0; end
      endcase
      adc_data_ch0 = d0;
      adc_data_ch1 = d1;
      force_trig = (idx == v.force_a) || (idx == v.force_b);
      arm = (idx == v.arm_at);
      sel = v.src ? d1 : d0;
      stopped = (idx == v.stop_at);
      if (stopped) begin
        if (v.stop_kind == 2) rst = 1'b1;
        else abort = 1'b1;
      end
      if (!stopped && t_exp < 0 && idx >= v.pre &&
          (force_trig || (idx >= 1 && crossing(int'(prev_sel), int'(sel), v.level, v.edg)))) begin
        t_exp = idx;
        n_exp = idx + DEPTH - v.pre;
      end
      @(negedge adc_clk);
      arm = 1'b0;
      force_trig = 1'b0;
      abort = 1'b0;
      rst = 1'b0;
      if (stopped) begin
        chk({v.name, "_stop_buf_wr"}, 64'(buf_wr), 64'd0);
        chk({v.name, "_stop_busy"}, 64'(busy), 64'd0);
        chk({v.name, "_stop_done"}, 64'(done), 64'd0);
        if (v.stop_kind == 2) begin
          chk({v.name, "_rst_buf_addr"}, 64'(buf_addr), 64'd0);
          chk({v.name, "_rst_buf_wdata"}, 64'(buf_wdata), 64'd0);
          chk({v.name, "_rst_trig_addr"}, 64'(trig_addr), 64'd0);
          chk({v.name, "_rst_start_addr"}, 64'(start_addr), 64'd0);
        end
        @(negedge adc_clk);
        chk({v.name, "_stop_buf_wr_hold"}, 64'(buf_wr), 64'd0);
        $display("run %s: stopped at capture %0d (kind %0d)", v.name, idx, v.stop_kind);
        return;
      end
      chk({v.name, "_wr"}, 64'(buf_wr), 64'd1);
      chk({v.name, "_addr"}, 64'(buf_addr), 64'(idx % DEPTH));
      chk({v.name, "_wdata"}, 64'(buf_wdata), 64'({d1, d0}));
      chk({v.name, "_busy"}, 64'(busy), 64'(idx != n_exp - 1));
      chk({v.name, "_done_low"}, 64'(done), 64'd0);
      prev_sel = sel;
      idx++;
      if (n_exp >= 0 && idx == n_exp) finished = 1;
    end
    if (!finished) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: %0d writes seen, record never completed", v.name, idx);
      return;
    end
    exp_t_addr = t_exp % DEPTH;
    exp_s_addr = (t_exp - v.pre + DEPTH) % DEPTH;
    @(negedge adc_clk);
    chk({v.name, "_end_buf_wr"}, 64'(buf_wr), 64'd0);
    chk({v.name, "_end_done"}, 64'(done), 64'd1);
    chk({v.name, "_end_busy"}, 64'(busy), 64'd0);
    chk({v.name, "_trig_addr"}, 64'(trig_addr), 64'(exp_t_addr));
    chk({v.name, "_start_addr"}, 64'(start_addr), 64'(exp_s_addr));
    if (v.exp_trig >= 0) begin
      chk({v.name, "_trig_addr_tbl"}, 64'(trig_addr), 64'(v.exp_trig));
      chk({v.name, "_start_addr_tbl"}, 64'(start_addr), 64'(v.exp_start));
      chk({v.name, "_writes_tbl"}, 64'(idx), 64'(v.exp_writes));
    end
    @(negedge adc_clk);
    chk({v.name, "_done_hold"}, 64'(done), 64'd1);
    $display("run %s: pre=%0d trig_addr=%0d start_addr=%0d writes=%0d", v.name, v.pre,
             trig_addr, start_addr, idx);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    tbl[0] = '{"pre0_force", 0,    0, 0, 0,   0, 0,  -1,   -1,  -1,  0, 0,   0,    2048};
    tbl[1] = '{"ramp_rise",  100,  0, 0, 0,   1, -1, -1,   500, -1,  0, 100, 0,    2048};
    tbl[2] = '{"step_fall",  1000, 1, 1, 0,   2, -1, -1,   -1,  -1,  0, 951, 1999, 4047};
    tbl[3] = '{"pre_block",  50,   0, 0, 0,   3, 20, -1,   -1,  -1,  0, 300, 250,  2298};
    tbl[4] = '{"pre_max",    2047, 1, 0, 0,   0, -1, 2100, -1,  -1,  0, -1,  -1,   -1};
    tbl[5] = '{"abort_post", 10,   0, 0, 0,   4, 20, -1,   -1,  500, 1, -1,  -1,   -1};
    tbl[6] = '{"rst_wait",   0,    0, 0, 0,   4, -1, -1,   -1,  300, 2, -1,  -1,   -1};
    tbl[7] = '{"restart",    5,    1, 1, 100, 0, -1, 400,  -1,  -1,  0, -1,  -1,   -1};

    repeat (3) @(negedge adc_clk);
    rst = 1'b0;
    chk("reset_buf_wr", 64'(buf_wr), 64'd0);
    chk("reset_buf_addr", 64'(buf_addr), 64'd0);
    chk("reset_buf_wdata", 64'(buf_wdata), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_trig_addr", 64'(trig_addr), 64'd0);
    chk("reset_start_addr", 64'(start_addr), 64'd0);

    for (int i = 0; i < 8; i++) run_case(tbl[i]);

    for (int i = 0; i < 4; i++) begin
      rv.name      = $sformatf("rand%0d", i);
      rv.pre       = int'($urandom_range(0, DEPTH - 1));
      rv.src       = 1'($urandom);
      rv.edg       = 1'($urandom);
      rv.level     = int'($urandom_range(0, 400)) - 200;
      rv.kind      = 0;
      rv.force_a   = -1;
      rv.force_b   = rv.pre + int'($urandom_range(0, 1500));
      rv.arm_at    = -1;
      rv.stop_at   = -1;
      rv.stop_kind = 0;
      rv.exp_trig  = -1;
      rv.exp_start = -1;
      rv.exp_writes = -1;
      run_case(rv);
    end

    // arm and abort together while done: abort wins, capture never starts
    @(negedge adc_clk);
    arm = 1'b1;
    abort = 1'b1;
    @(negedge adc_clk);
    arm = 1'b0;
    abort = 1'b0;
    chk("arm_abort_busy", 64'(busy), 64'd0);
    chk("arm_abort_buf_wr", 64'(buf_wr), 64'd0);
    chk("arm_abort_done", 64'(done), 64'd0);
    @(negedge adc_clk);
    chk("arm_abort_buf_wr_hold", 64'(buf_wr), 64'd0);
    $display("run arm_abort: busy=%0d buf_wr=%0d done=%0d", busy, buf_wr, done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
